// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the core load/store path and the debug/DMA port for one byte-lane data memory.
// Optional DMEM_SIGN_EXT_EN: byte/half reads sign-extend instead of zero-extend.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [1:0]    size0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [1:0]    size1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_write,
  output logic [1:0]    mem_read,
  input  logic [DW-1:0] mem_rdata
);

`ifdef DMEM_SIGN_EXT_EN
  localparam logic SIGN_EXT = 1'b1;
`else
  localparam logic SIGN_EXT = 1'b0;
`endif

  localparam logic [1:0] SZ_HALF = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] NO_WRITE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        state_q;
  logic          sel_q;
  logic          ptr_q;
  logic          gnt0_q, gnt1_q, done0_q, done1_q;
  logic [DW-1:0] cap_q;

  logic          win_d;
  logic          any_req;
  logic          sel_we;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [DW-1:0] fmt_d;

  assign any_req   = req0 | req1;
  assign sel_we    = sel_q ? we1    : we0;
  assign sel_size  = sel_q ? size1  : size0;
  assign sel_addr  = sel_q ? addr1  : addr0;
  assign sel_wdata = sel_q ? wdata1 : wdata0;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    if (req0 && !req1)      win_d = 1'b0;
    else if (req1 && !req0) win_d = 1'b1;
    else                    win_d = ~ptr_q;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = NO_WRITE;
    mem_read  = 2'b00;
    if (state_q == S_ACCESS) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      if (sel_we)
        mem_write = sel_size;
      else if (sel_size == SZ_WORD || sel_size == SZ_HALF)
        mem_read = 2'b01;
    end
    // Reset must block the falling-edge write even in the middle of an access.
    if (!rst_n)
      mem_write = NO_WRITE;
  end

  always_comb begin
    fmt_d = '0;
    if (!sel_we) begin
      case (sel_size)
        SZ_WORD: fmt_d = mem_rdata;
        SZ_HALF: fmt_d = {{(DW-16){SIGN_EXT & mem_rdata[15]}}, mem_rdata[15:0]};
        SZ_BYTE: fmt_d = {{(DW-8){SIGN_EXT & mem_rdata[7]}}, mem_rdata[7:0]};
        default: fmt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      ptr_q   <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      cap_q   <= '0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (any_req) begin
            state_q <= S_ACCESS;
            sel_q   <= win_d;
            ptr_q   <= win_d;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ACCESS: begin
          state_q <= S_DONE;
          cap_q   <= fmt_d;
          done0_q <= ~sel_q;
          done1_q <= sel_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign rdata0 = done0_q ? cap_q : '0;
  assign rdata1 = done1_q ? cap_q : '0;

endmodule
